dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline memory stage (CPU) and a host/loader port.
- The host port is used by benches or a boot loader to preload arrays and poll done flags at run time, instead of backdoor writes.
- CPU has fixed priority, with a starvation guard that guarantees the host a slot.
- Sits between the M stage / dmem and the external debug interconnect; drives the pipeline stall for memory conflicts.

Parameters:
- ADDR_W, 14, byte-address width (word address = addr[ADDR_W-1:2])
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive blocked host cycles before host is forced a slot; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  M-stage memory access request (load or store)
- cpu_we  in  1  1 = store
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_req & !cpu_we & !cpu_stall
- cpu_stall  out  1  freeze pipeline this cycle
- host_valid  in  1  host request valid
- host_ready  out  1  host request accepted this cycle
- host_we  in  1  1 = write
- host_addr  in  ADDR_W  byte address
- host_wdata  in  DATA_W  write data
- host_rvalid  out  1  read response pulse
- host_rdata  out  DATA_W  read data, valid with host_rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_en & !mem_we
- perf_cpu_stalls  out  32  stall-cycle counter (optional feature)
- perf_host_xfers  out  32  host transfer counter (optional feature)

Behaviour:
- States: ARB, CPU_RD, HOST_RD. Reset state is ARB.
- Reset values: all outputs 0; starve_cnt = 0.
- force_host = host_valid & (starve_cnt == STARVE_LIMIT).
- In ARB:
  - CPU granted if cpu_req & !force_host; otherwise host granted if host_valid.
  - Granted requester drives mem_en/mem_we/mem_addr/mem_wdata combinationally the same cycle.
- CPU store granted: single cycle, cpu_stall = 0; remain in ARB.
- CPU load granted: cpu_stall = 1, go to CPU_RD.
- In CPU_RD:
  - mem_en = 0, cpu_rdata = mem_rdata, cpu_stall = 0, return to ARB.
  - Load latency is 1 stall cycle.
- Host granted: host_ready = 1, and cpu_stall = cpu_req.
  - Host write: stay in ARB.
  - Host read: go to HOST_RD.
- In HOST_RD:
  - host_rvalid = 1, host_rdata = mem_rdata, cpu_stall = cpu_req, return to ARB.
  - Host read latency is 1 cycle after host_ready.
- host_ready is 0 in CPU_RD and HOST_RD; at most one access is outstanding.
- starve_cnt:
  - Clears on any host handshake.
  - Otherwise increments when host_valid & !host_ready.
  - Saturates at STARVE_LIMIT; holds when host_valid = 0.
- Host request fields must stay stable while host_valid & !host_ready. Dropping host_valid before accept is legal and holds starve_cnt.
- addr[1:0] are ignored: word accesses only, no byte enables.
- When cpu_req = 0, cpu_stall = 0 except in the HOST_RD/host-grant cases above.
- Async reset mid-operation aborts any in-flight read: no host_rvalid, FSM to ARB, perf counters cleared.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- With the macro defined:
  - perf_cpu_stalls increments every cycle cpu_stall = 1.
  - perf_host_xfers increments on every host handshake.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- Without the macro: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared package dmem_arb_pkg:
  - arb_state_t enum (ARB, CPU_RD, HOST_RD)
  - constants DMEM_ADDR_W = 14 and DMEM_DATA_W = 32
  - host request struct (we, addr, wdata)
- One natural sub-module: dmem_arb_starve_ctr (saturating counter with clear/inc/limit compare).
- FSM and muxing stay in the top module.

Test Plan:
- Host writes 10..1 to byte addrs 0x100..0x124 with cpu_req = 0 -> host_ready each ARB cycle, mem_we = 1, mem_addr = 0x40..0x49, no cpu_stall.
- CPU load 0x100 with mem holding 10 -> cpu_stall = 1 for exactly 1 cycle, then cpu_rdata = 10 with cpu_stall = 0.
- cpu_req stores held continuously with host_valid read of 0x200 (mem = 1), STARVE_LIMIT = 4 -> host blocked 4 cycles, 5th cycle host_ready = 1 and cpu_stall = 1, next cycle host_rvalid = 1 with host_rdata = 1 and cpu_stall = 1, then CPU resumes.
- cpu_req and host_valid both rise in the same cycle with starve_cnt = 0 -> CPU granted first, host_ready = 0.
- Host read accepted, reset asserted low in HOST_RD -> all outputs 0 immediately, no host_rvalid after reset release, state ARB.
- With DMEM_ARB_PERF_EN: 3 CPU loads plus 2 host writes with no conflict -> perf_cpu_stalls = 3, perf_host_xfers = 2. Without the macro both read 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// No logic; imported by the arbiter top and its starvation counter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 14;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        CPU_RD  = 2'd1,
        HOST_RD = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } host_req_t;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of consecutive blocked host cycles; flags when the limit is reached.
// Latency: count updates on the clock edge, at_limit is a direct compare of the count.
// Backpressure: none; clr wins over inc, the count holds when neither is asserted.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != 4'(LIMIT))) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign at_limit = (cnt_q == 4'(LIMIT));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the M stage (fixed priority) and a host port. Optional perf counters: DMEM_ARB_PERF_EN.
// Latency: grant drives the memory combinationally; load data returns one cycle after the grant.
// Backpressure: cpu_stall freezes the pipeline, host_ready holds the host off; STARVE_LIMIT blocked cycles force a host slot.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       perf_cpu_stalls,
    output logic [31:0]       perf_host_xfers
);

    arb_state_t state_q, state_d;
    logic       starve_full;
    logic       force_host;
    logic       host_hs;
    logic       unused_byte_offsets;

    // Word accesses only: the byte offset bits carry no meaning here.
    assign unused_byte_offsets = ^{cpu_addr[1:0], host_addr[1:0]};

    assign force_host = host_valid & starve_full;
    assign host_hs    = host_valid & host_ready;

    dmem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clr      (host_hs),
        .inc      (host_valid & ~host_ready),
        .at_limit (starve_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_stall   = 1'b0;
        cpu_rdata   = '0;
        host_ready  = 1'b0;
        host_rvalid = 1'b0;
        host_rdata  = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state_q)
            ARB: begin
                if (cpu_req && !force_host) begin
                    mem_en    = 1'b1;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr[ADDR_W-1:2];
                    mem_wdata = cpu_wdata;
                    if (!cpu_we) begin
                        cpu_stall = 1'b1;
                        state_d   = CPU_RD;
                    end
                end else if (host_valid) begin
                    host_ready = 1'b1;
                    mem_en     = 1'b1;
                    mem_we     = host_we;
                    mem_addr   = host_addr[ADDR_W-1:2];
                    mem_wdata  = host_wdata;
                    cpu_stall  = cpu_req;
                    if (!host_we) begin
                        state_d = HOST_RD;
                    end
                end
            end
            CPU_RD: begin
                cpu_rdata = mem_rdata;
                state_d   = ARB;
            end
            HOST_RD: begin
                // The M stage keeps waiting while the host's read data returns.
                host_rvalid = 1'b1;
                host_rdata  = mem_rdata;
                cpu_stall   = cpu_req;
                state_d     = ARB;
            end
            default: state_d = ARB;
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cpu_stalls <= '0;
            perf_host_xfers <= '0;
        end else begin
            if (cpu_stall) perf_cpu_stalls <= perf_cpu_stalls + 32'd1;
            if (host_hs)   perf_host_xfers <= perf_host_xfers + 32'd1;
        end
    end
`else
    assign perf_cpu_stalls = '0;
    assign perf_host_xfers = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural sync RAM, vector table plus hand sequences, host-read scoreboard.
// Build with or without DMEM_ARB_PERF_EN; the perf expectations follow the macro.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [13:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic        host_valid = 1'b0, host_ready, host_we = 1'b0;
    logic [13:0] host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_en, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = '0;
    logic [31:0] perf_cpu_stalls, perf_host_xfers;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ram     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] exp_q   [$];

    typedef struct {
        logic        cpu_req, cpu_we;
        logic [13:0] cpu_addr;
        logic        host_valid, host_we;
        logic [13:0] host_addr;
        logic [31:0] wdata;
        logic        e_stall, e_ready, e_en, e_we;
        logic [11:0] e_addr;
    } vec_t;

    vec_t vt [8];

    dmem_port_arbiter #(
        .ADDR_W       (14),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_stall       (cpu_stall),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata      (host_wdata),
        .host_rvalid     (host_rvalid),
        .host_rdata      (host_rdata),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .perf_cpu_stalls (perf_cpu_stalls),
        .perf_host_xfers (perf_host_xfers)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: host reads queue their expected word at handshake, compared when rvalid fires.
    always @(negedge clk) begin
        if (reset) begin
            if (host_valid && host_ready) begin
                if (host_we) ref_mem[host_addr[13:2]] = host_wdata;
                else         exp_q.push_back(ref_mem[host_addr[13:2]]);
            end
            if (cpu_req && !cpu_stall) begin
                if (cpu_we) ref_mem[cpu_addr[13:2]] = cpu_wdata;
                else        chk("cpu_rdata_sb", cpu_rdata, ref_mem[cpu_addr[13:2]]);
            end
            if (host_rvalid) begin
                if (exp_q.size() == 0) chk("host_rvalid_unexpected", {31'd0, host_rvalid}, 32'd0);
                else                   chk("host_rdata_sb", host_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; host_valid = 1'b0; host_we = 1'b0;
    endtask

    task automatic host_drive(input logic we, input logic [13:0] a, input logic [31:0] d);
        host_valid = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    task automatic cpu_drive(input logic we, input logic [13:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    function automatic vec_t mk(input logic cr, input logic cw, input logic [13:0] ca,
                                input logic hv, input logic hw, input logic [13:0] ha,
                                input logic [31:0] wd, input logic es, input logic er,
                                input logic ee, input logic ew, input logic [11:0] ea);
        vec_t v;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca;
        v.host_valid = hv; v.host_we = hw; v.host_addr = ha; v.wdata = wd;
        v.e_stall = es; v.e_ready = er; v.e_en = ee; v.e_we = ew; v.e_addr = ea;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        //           cr cw ca      hv hw ha      wdata  stall rdy en we addr
        vt[0] = mk(0, 0, 14'h0,   0, 0, 14'h0,   32'h0,  0, 0, 0, 0, 12'h0);
        vt[1] = mk(1, 1, 14'h10,  0, 0, 14'h0,   32'h11, 0, 0, 1, 1, 12'h4);
        vt[2] = mk(1, 0, 14'h14,  0, 0, 14'h0,   32'h0,  1, 0, 1, 0, 12'h5);
        vt[3] = mk(1, 1, 14'h30,  1, 0, 14'h34,  32'h33, 0, 0, 1, 1, 12'hC);
        vt[4] = mk(1, 0, 14'h38,  1, 1, 14'h3C,  32'h44, 1, 0, 1, 0, 12'hE);
        vt[5] = mk(0, 0, 14'h0,   1, 1, 14'h20,  32'h55, 0, 1, 1, 1, 12'h8);
        vt[6] = mk(0, 0, 14'h0,   1, 0, 14'h24,  32'h0,  0, 1, 1, 0, 12'h9);
        vt[7] = mk(0, 0, 14'h0,   1, 1, 14'h107, 32'h5A, 0, 1, 1, 1, 12'h41);

        // Reset state
        #2;
        chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_host_ready", {31'd0, host_ready}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_perf_stalls", perf_cpu_stalls, 32'd0);
        chk("rst_perf_xfers", perf_host_xfers, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Host preloads 10..1 into 0x100..0x124 with the CPU idle
        for (int i = 0; i < 10; i++) begin
            host_drive(1'b1, 14'(14'h100 + 4 * i), 32'(10 - i));
            @(negedge clk);
            chk("preload_ready", {31'd0, host_ready}, 32'd1);
            chk("preload_we", {31'd0, mem_we}, 32'd1);
            chk("preload_addr", {20'd0, mem_addr}, 32'(12'h40 + i));
            chk("preload_wdata", mem_wdata, 32'(10 - i));
            chk("preload_stall", {31'd0, cpu_stall}, 32'd0);
            cyc();
        end
        idle();

        // CPU load of 0x100: one stall cycle, then data
        cpu_drive(1'b0, 14'h100, 32'h0);
        @(negedge clk);
        chk("ld_stall_c1", {31'd0, cpu_stall}, 32'd1);
        chk("ld_addr", {20'd0, mem_addr}, 32'h40);
        cyc();
        @(negedge clk);
        chk("ld_stall_c2", {31'd0, cpu_stall}, 32'd0);
        chk("ld_rdata", cpu_rdata, 32'd10);
        cyc();
        idle();

        // Starvation: continuous CPU stores against a host read of 0x200
        host_drive(1'b1, 14'h200, 32'd1);
        cyc();
        idle();
        host_drive(1'b0, 14'h200, 32'h0);
        cpu_drive(1'b1, 14'h300, 32'hDEAD_0000);
        for (int k = 0; k < 4; k++) begin
            cpu_wdata = 32'hDEAD_0000 + 32'(k);
            @(negedge clk);
            chk("starve_blocked_ready", {31'd0, host_ready}, 32'd0);
            chk("starve_blocked_stall", {31'd0, cpu_stall}, 32'd0);
            chk("starve_blocked_addr", {20'd0, mem_addr}, 32'hC0);
            cyc();
        end
        @(negedge clk);
        chk("starve_force_ready", {31'd0, host_ready}, 32'd1);
        chk("starve_force_stall", {31'd0, cpu_stall}, 32'd1);
        chk("starve_force_addr", {20'd0, mem_addr}, 32'h80);
        chk("starve_force_we", {31'd0, mem_we}, 32'd0);
        cyc();
        host_valid = 1'b0;
        @(negedge clk);
        chk("starve_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk("starve_rdata", host_rdata, 32'd1);
        chk("starve_rd_stall", {31'd0, cpu_stall}, 32'd1);
        cyc();
        @(negedge clk);
        chk("starve_resume_stall", {31'd0, cpu_stall}, 32'd0);
        chk("starve_resume_en", {31'd0, mem_en & mem_we}, 32'd1);
        cyc();
        idle();

        // Single-cycle grant vectors from ARB, each followed by idle cycles
        for (int v = 0; v < 8; v++) begin
            cpu_req = vt[v].cpu_req; cpu_we = vt[v].cpu_we; cpu_addr = vt[v].cpu_addr;
            cpu_wdata = vt[v].wdata;
            host_valid = vt[v].host_valid; host_we = vt[v].host_we;
            host_addr = vt[v].host_addr; host_wdata = vt[v].wdata;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", v), {31'd0, cpu_stall}, {31'd0, vt[v].e_stall});
            chk($sformatf("vec%0d_ready", v), {31'd0, host_ready}, {31'd0, vt[v].e_ready});
            chk($sformatf("vec%0d_en", v), {31'd0, mem_en}, {31'd0, vt[v].e_en});
            if (vt[v].e_en) begin
                chk($sformatf("vec%0d_we", v), {31'd0, mem_we}, {31'd0, vt[v].e_we});
                chk($sformatf("vec%0d_addr", v), {20'd0, mem_addr}, {20'd0, vt[v].e_addr});
            end
            cyc();
            idle();
            repeat (2) cyc();
        end

        // Reset in HOST_RD aborts the read
        host_drive(1'b0, 14'h100, 32'h0);
        @(negedge clk);
        chk("abort_ready", {31'd0, host_ready}, 32'd1);
        cyc();
        idle();
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("abort_stall", {31'd0, cpu_stall}, 32'd0);
        chk("abort_en", {31'd0, mem_en}, 32'd0);
        chk("abort_rdata", host_rdata, 32'd0);
        chk("abort_perf_stalls", perf_cpu_stalls, 32'd0);
        chk("abort_perf_xfers", perf_host_xfers, 32'd0);
        cyc();
        reset = 1'b1;
        cpu_drive(1'b1, 14'h300, 32'h1234);
        @(negedge clk);
        chk("post_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("post_rst_arb_en", {31'd0, mem_en}, 32'd1);
        chk("post_rst_arb_stall", {31'd0, cpu_stall}, 32'd0);
        cyc();
        idle();

        // Perf: 3 CPU loads and 2 host writes, no conflicts
        for (int i = 0; i < 3; i++) begin
            cpu_drive(1'b0, 14'(14'h104 + 4 * i), 32'h0);
            repeat (2) cyc();
            idle();
        end
        for (int i = 0; i < 2; i++) begin
            host_drive(1'b1, 14'(14'h400 + 4 * i), 32'(i + 7));
            cyc();
            idle();
        end
        @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_cpu_stalls", perf_cpu_stalls, 32'd3);
        chk("perf_host_xfers", perf_host_xfers, 32'd2);
`else
        chk("perf_cpu_stalls_off", perf_cpu_stalls, 32'd0);
        chk("perf_host_xfers_off", perf_host_xfers, 32'd0);
`endif
        cyc();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
